// File: rtl/task_test_core.sv
// Four-channel pulse monitor: synchronises each bit of `a`, strobes on edges,
// counts rising edges and measures the high width of every pulse in Clk cycles.
module task_test_core #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int WID_W       = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [3:0]           a,
    output logic [3:0]           rise_pulse,
    output logic [3:0]           fall_pulse,
    output logic [4*CNT_W-1:0]   rise_cnt,
    output logic [4*WID_W-1:0]   width,
    output logic [3:0]           width_valid
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0] arm_cnt_reg;
    logic             armed;

    // Edges are ignored until the chain and prev flop reflect the real input level.
    assign armed = (arm_cnt_reg == ARM_W'(ARM_MAX));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            arm_cnt_reg <= '0;
        end else if (!armed) begin
            arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   wv_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [WID_W-1:0]       wcnt_reg;
            logic [WID_W-1:0]       width_reg;
            logic                   s;
            logic                   rise;
            logic                   fall;

            assign s    = sync_reg[SYNC_STAGES-1];
            assign rise = armed & s & ~prev_reg;
            assign fall = armed & ~s & prev_reg;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    sync_reg  <= '0;
                    prev_reg  <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    wv_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    wcnt_reg  <= '0;
                    width_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], a[gi]};
                    prev_reg <= s;
                    rise_reg <= rise;
                    fall_reg <= fall;
                    wv_reg   <= 1'b0;
                    if (rise) begin
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                        wcnt_reg <= WID_W'(1);
                    end else if (fall) begin
                        // A zero count means no rise was seen since arming: nothing to report.
                        if (wcnt_reg != '0) begin
                            width_reg <= wcnt_reg;
                            wv_reg    <= 1'b1;
                        end
                        wcnt_reg <= '0;
                    end else if (s && prev_reg && (wcnt_reg != '0) && (wcnt_reg != '1)) begin
                        wcnt_reg <= wcnt_reg + WID_W'(1);
                    end
                end
            end

            assign rise_pulse[gi]              = rise_reg;
            assign fall_pulse[gi]              = fall_reg;
            assign width_valid[gi]             = wv_reg;
            assign rise_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
            assign width[gi*WID_W +: WID_W]    = width_reg;
        end
    endgenerate

endmodule

// File: tb/tb_task_test_core.sv
// Directed bench for task_test_core: strobe counting, latency, widths,
// async reset mid-pulse, counter wrap, width saturation and simultaneous channels.
module tb_task_test_core;

    logic        Clk;
    logic        Reset;
    logic [3:0]  a;
    logic [3:0]  rise_pulse;
    logic [3:0]  fall_pulse;
    logic [31:0] rise_cnt;
    logic [63:0] width;
    logic [3:0]  width_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_seen [4];
    int fall_seen [4];
    int wv_seen   [4];
    int last_rise [4];
    int last_fall [4];
    int last_wv   [4];
    int chg_r, chg_f, snap_r, snap_w, snap_f;

    task_test_core dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .a           (a),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .rise_cnt    (rise_cnt),
        .width       (width),
        .width_valid (width_valid)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rise_pulse[n])  begin rise_seen[n]++; last_rise[n] = cyc; end
            if (fall_pulse[n])  begin fall_seen[n]++; last_fall[n] = cyc; end
            if (width_valid[n]) begin wv_seen[n]++;   last_wv[n]   = cyc; end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            rise_seen[n] = 0; fall_seen[n] = 0; wv_seen[n] = 0;
            last_rise[n] = 0; last_fall[n] = 0; last_wv[n] = 0;
        end
        Reset = 1'b1;
        a     = 4'b0001;
        #201 Reset = 1'b0;
        #200;
        chk("rst_rise_seen", rise_seen[0] + rise_seen[1] + rise_seen[2] + rise_seen[3], 0);
        chk("rst_fall_seen", fall_seen[0] + fall_seen[1] + fall_seen[2] + fall_seen[3], 0);
        chk("rst_rise_cnt", rise_cnt, 0);
        chk("rst_width", width, 0);
        chk("rst_wv_seen", wv_seen[0] + wv_seen[1] + wv_seen[2] + wv_seen[3], 0);

        // Channel 0: initial fall (no measurement), then a 10-cycle pulse
        @(negedge Clk); a[0] = 1'b0; chg_f = cyc + 1;
        cycles(10);
        chk("ch0_fall1", fall_seen[0], 1);
        chk("ch0_fall1_lat", last_fall[0] - chg_f, 2);
        chk("ch0_fall1_nowv", wv_seen[0], 0);
        a[0] = 1'b1; chg_r = cyc + 1;
        cycles(10);
        a[0] = 1'b0; chg_f = cyc + 1;
        cycles(6);
        chk("ch0_rise_seen", rise_seen[0], 1);
        chk("ch0_rise_lat", last_rise[0] - chg_r, 2);
        chk("ch0_fall2", fall_seen[0], 2);
        chk("ch0_fall2_lat", last_fall[0] - chg_f, 2);
        chk("ch0_cnt", rise_cnt[7:0], 1);
        chk("ch0_wv_seen", wv_seen[0], 1);
        chk("ch0_wv_cyc", last_wv[0], last_fall[0]);
        chk("ch0_width", width[15:0], 10);

        // Channel 3: 10-cycle pulse, channel 0 undisturbed
        cycles(40);
        a[3] = 1'b1;
        cycles(10);
        a[3] = 1'b0;
        cycles(6);
        chk("ch3_cnt", rise_cnt[31:24], 1);
        chk("ch3_width", width[63:48], 10);
        chk("ch3_wv_seen", wv_seen[3], 1);
        chk("ch0_cnt_hold", rise_cnt[7:0], 1);
        chk("ch0_width_hold", width[15:0], 10);

        // Channel 1: async reset mid-pulse, release with input still high
        a[1] = 1'b1;
        cycles(5);
        snap_w = wv_seen[1]; snap_f = fall_seen[1];
        #3 Reset = 1'b1;
        #1;
        chk("arst_rise_cnt", rise_cnt, 0);
        chk("arst_width", width, 0);
        chk("arst_strobes", {rise_pulse, fall_pulse, width_valid}, 0);
        cycles(2);
        Reset = 1'b0;
        snap_r = rise_seen[1];
        cycles(8);
        chk("rel_no_rise", rise_seen[1] - snap_r, 0);
        chk("rel_cnt1", rise_cnt[15:8], 0);
        chk("rel_no_wv", wv_seen[1] - snap_w, 0);
        a[1] = 1'b0;
        cycles(5);
        chk("rel_fall_seen", fall_seen[1] - snap_f, 1);
        chk("rel_fall_nowv", wv_seen[1] - snap_w, 0);
        a[1] = 1'b1;
        cycles(5);
        a[1] = 1'b0;
        cycles(6);
        chk("ch1_width", width[31:16], 5);
        chk("ch1_cnt", rise_cnt[15:8], 1);
        chk("ch1_wv_seen", wv_seen[1] - snap_w, 1);

        // Channel 2: 256 pulses wrap the counter, then a saturating hold
        for (int p = 0; p < 256; p++) begin
            a[2] = 1'b1; cycles(2);
            a[2] = 1'b0; cycles(2);
            if (p == 254) begin
                cycles(4);
                chk("ch2_cnt_255", rise_cnt[23:16], 255);
            end
        end
        cycles(4);
        chk("ch2_cnt_wrap", rise_cnt[23:16], 0);
        chk("ch2_rise_seen", rise_seen[2], 256);
        chk("ch2_width2", width[47:32], 2);
        a[2] = 1'b1;
        cycles(65540);
        a[2] = 1'b0;
        cycles(6);
        chk("ch2_width_sat", width[47:32], 65535);

        // Channels 0 and 1 together for 4 cycles
        a[1:0] = 2'b11;
        cycles(4);
        a[1:0] = 2'b00;
        cycles(6);
        chk("sim_rise_cyc", last_rise[1], last_rise[0]);
        chk("sim_wv_cyc", last_wv[1], last_wv[0]);
        chk("sim_width0", width[15:0], 4);
        chk("sim_width1", width[31:16], 4);
        chk("sim_cnt0", rise_cnt[7:0], 1);
        chk("sim_cnt1", rise_cnt[15:8], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
